mux_2x1_arbiter: RTL and testbench

MUX_2X1_ARBITER -- requirements
Module: mux_2x1_arbiter

---
 rtl/mux_2x1_arbiter.sv | 95 +++++++++
 tb/tb_mux_2x1_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// Two-input round-robin arbiter driving a 2:1 data mux with a
// valid/ready output. A grant lasts until the granted requester drops
// its req or MAX_BURST beats have been transferred. When both requesters
// want the output, the one not served last wins.
module mux_2x1_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [WIDTH-1:0] a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] c,
   output logic             c_valid,
   input  logic             c_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   // Counter value at which the next transfer is the last one of a burst.
   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t     state_reg, state_next;
   logic [7:0] count_reg, count_next;
   logic       last_b_reg, last_b_next;   // 1: B was served most recently
   logic       grant_end;
   logic       xfer;

   // Grant and select come straight from the state register.
   assign gnt_a   = (state_reg == GNT_A);
   assign gnt_b   = (state_reg == GNT_B);
   assign sel     = (state_reg == GNT_B);
   assign c       = sel ? b : a;
   assign c_valid = (gnt_a & req_a) | (gnt_b & req_b);
   assign xfer    = c_valid & c_ready;

   // State, burst counter and last-served flag; reset aborts any burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= 8'd0;
         last_b_reg <= 1'b1;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         last_b_reg <= last_b_next;
      end
   end

   // Decide whether the current grant ends and who owns the output next.
   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      last_b_next = last_b_reg;
      grant_end   = 1'b0;

      case (state_reg)
         IDLE:    grant_end = 1'b1;
         GNT_A:   grant_end = !req_a || (xfer && (count_reg == LAST_BEAT));
         GNT_B:   grant_end = !req_b || (xfer && (count_reg == LAST_BEAT));
         default: grant_end = 1'b1;
      endcase

      if (grant_end) begin
         // Every (re-)entry into a grant starts a fresh burst, including
         // re-granting the same requester after its burst limit.
         count_next = 8'd0;
         if (req_a && req_b)
            state_next = last_b_reg ? GNT_A : GNT_B;
         else if (req_a)
            state_next = GNT_A;
         else if (req_b)
            state_next = GNT_B;
         else
            state_next = IDLE;

         if (state_next == GNT_A)
            last_b_next = 1'b0;
         else if (state_next == GNT_B)
            last_b_next = 1'b1;
      end else if (xfer) begin
         count_next = count_reg + 8'd1;
      end
   end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Bench for mux_2x1_arbiter: directed scenarios with literal expectations
// plus a per-cycle comparison against an owner/beat-count model.
module tb_mux_2x1_arbiter;

   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_a, req_b, c_ready;
   logic [WIDTH-1:0] a, b;
   logic             gnt_a, gnt_b, sel, c_valid;
   logic [WIDTH-1:0] c;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Model: who owns the output (0 none, 1 A, 2 B), beats done in this
   // grant, and who was served last (1 A, 2 B).
   int m_owner = 0;
   int m_beats = 0;
   int m_last  = 2;

   mux_2x1_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .a(a), .req_b(req_b), .b(b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
      .c(c), .c_valid(c_valid), .c_ready(c_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   // Model update: finish or continue the current grant, pick the next owner.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = 0;
         m_beats = 0;
         m_last  = 2;
      end else begin
         bit cur_req, moved, done;
         cur_req = (m_owner == 1) ? req_a : (m_owner == 2) ? req_b : 1'b0;
         moved   = cur_req && c_ready;
         done    = (m_owner == 0) || !cur_req || (moved && (m_beats + 1 == MAX_BURST));
         if (done) begin
            if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
            else if (req_a)     m_owner = 1;
            else if (req_b)     m_owner = 2;
            else                m_owner = 0;
            m_beats = 0;
            if (m_owner != 0) m_last = m_owner;
         end else if (moved) begin
            m_beats++;
         end
      end
   end

   // Compare DUT outputs with the model away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         logic exp_valid;
         exp_valid = (m_owner == 1) ? req_a : (m_owner == 2) ? req_b : 1'b0;
         chk("m_gnt_a",   32'(gnt_a),   32'(m_owner == 1));
         chk("m_gnt_b",   32'(gnt_b),   32'(m_owner == 2));
         chk("m_sel",     32'(sel),     32'(m_owner == 2));
         chk("m_c",       32'(c),       32'((m_owner == 2) ? b : a));
         chk("m_c_valid", 32'(c_valid), 32'(exp_valid));
         chk("one_hot_gnt", 32'(gnt_a & gnt_b), 32'(0));
         if (c_valid && c_ready && !rst)
            $display("xfer t=%0t owner=%0d c=%h", $time, m_owner, c);
      end
   end

   initial begin
      req_a = 0; req_b = 0; c_ready = 0; a = 8'h11; b = 8'h22;

      // Reset state and a single requester A: 1-cycle grant, 4 beats, re-grant.
      step(2);
      chk_on = 1'b1;
      chk("rst_gnt_a", 32'(gnt_a), 32'(0));
      chk("rst_gnt_b", 32'(gnt_b), 32'(0));
      chk("rst_sel", 32'(sel), 32'(0));
      chk("rst_c_valid", 32'(c_valid), 32'(0));
      chk("rst_c", 32'(c), 32'h11);
      rst = 1'b0; req_a = 1; c_ready = 1;
      #1 chk("idle_no_gnt", 32'(gnt_a), 32'(0));
      step(1);
      chk("s1_gnt_a", 32'(gnt_a), 32'(1));
      chk("s1_c", 32'(c), 32'h11);
      chk("s1_c_valid", 32'(c_valid), 32'(1));
      step(4);
      chk("s1_regrant_a", 32'(gnt_a), 32'(1));
      chk("s1_regrant_sel", 32'(sel), 32'(0));
      req_a = 0;
      step(1);
      chk("s1_idle", 32'(gnt_a), 32'(0));

      // Both requesting: A,B,A,B every 4 beats, no idle gaps.
      do_reset();
      req_a = 1; req_b = 1; c_ready = 1; a = 8'h33; b = 8'h44;
      step(1); chk("s2_first_a", 32'(gnt_a), 32'(1));
      step(3); chk("s2_hold_a", 32'(gnt_a), 32'(1));
      step(1); chk("s2_then_b_sel", 32'(sel), 32'(1));
      chk("s2_then_b_c", 32'(c), 32'h44);
      step(4); chk("s2_back_a_sel", 32'(sel), 32'(0));
      chk("s2_back_a", 32'(gnt_a), 32'(1));
      step(4); chk("s2_b_again", 32'(gnt_b), 32'(1));

      // B stalled by c_ready=0: held, counter only moves once ready.
      do_reset();
      req_a = 0; req_b = 1; c_ready = 0; b = 8'hAA;
      step(1);
      req_a = 1;   // non-granted req must not disturb the grant
      for (int i = 0; i < 3; i++) begin
         chk("s3_stall_gnt_b", 32'(gnt_b), 32'(1));
         chk("s3_stall_c", 32'(c), 32'hAA);
         chk("s3_stall_valid", 32'(c_valid), 32'(1));
         step(1);
      end
      chk("s3_still_b", 32'(gnt_b), 32'(1));
      c_ready = 1;
      step(3); chk("s3_b_3beats", 32'(gnt_b), 32'(1));
      step(1); chk("s3_to_a", 32'(gnt_a), 32'(1));

      // A drops after 2 beats with B waiting: direct switch, fresh count.
      do_reset();
      req_a = 1; req_b = 0; c_ready = 1; a = 8'h55; b = 8'h66;
      step(1); chk("s4_gnt_a", 32'(gnt_a), 32'(1));
      step(2);
      req_a = 0; req_b = 1;
      #1 chk("s4_valid_drop", 32'(c_valid), 32'(0));
      step(1);
      chk("s4_gnt_b", 32'(gnt_b), 32'(1));
      chk("s4_sel", 32'(sel), 32'(1));
      req_a = 1;
      step(3); chk("s4_b_full_burst", 32'(gnt_b), 32'(1));
      step(1); chk("s4_back_a", 32'(gnt_a), 32'(1));

      // Asynchronous reset in the middle of a B grant.
      do_reset();
      req_a = 0; req_b = 1; c_ready = 1; a = 8'h77; b = 8'h88;
      step(1); chk("s5_gnt_b", 32'(gnt_b), 32'(1));
      req_a = 1;
      #3 rst = 1'b1;
      #1;
      chk("s5_async_gnt_b", 32'(gnt_b), 32'(0));
      chk("s5_async_sel", 32'(sel), 32'(0));
      chk("s5_async_valid", 32'(c_valid), 32'(0));
      chk("s5_async_c", 32'(c), 32'h77);
      #2 rst = 1'b0;
      step(1); chk("s5_a_first", 32'(gnt_a), 32'(1));

      // Random sweep of {req_a, req_b, c_ready}; the model checks every cycle.
      for (int i = 0; i < 1000; i++) begin
         {req_a, req_b, c_ready} = 3'($urandom_range(0, 7));
         a = 8'($urandom);
         b = 8'($urandom);
         step(1);
         chk("rnd_sel_eq_gnt_b", 32'(sel), 32'(gnt_b));
      end

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
